// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
// Holds the state encoding, ALU op codes, mux selects and opcodes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWRITE  = 4'd4,
        S_MEMWB     = 4'd5,
        S_EXECR     = 4'd6,
        S_EXECI     = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14,
        S_TRAP      = 4'd15
    } state_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    function automatic logic [3:0] alu_fn(logic [2:0] f3, logic alt);
        logic [3:0] r;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] imm_src(logic [6:0] op);
        logic [2:0] r;
        case (op)
            OP_STORE:        r = IMM_S;
            OP_BR:           r = IMM_B;
            OP_JAL:          r = IMM_J;
            OP_LUI, OP_AUIPC: r = IMM_U;
            default:         r = IMM_I;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready bundle between the controller and memory.
// The controller drives the request side, memory answers with ready.
interface multicycle_ctrl_if;
    logic       mem_req;
    logic       mem_ready;
    logic       MemWrite;
    logic [1:0] MemSize;
    logic       MemUnsigned;

    modport master (
        output mem_req, MemWrite, MemSize, MemUnsigned,
        input  mem_ready
    );

    modport slave (
        input  mem_req, MemWrite, MemSize, MemUnsigned,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational IR field decoder: ALU operation and legality check.
// Covers every RV32I base opcode the controller dispatches on.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic f7_zero;
    logic f7_alt;

    assign f7_zero = (func7 == 7'b0000000);
    assign f7_alt  = (func7 == 7'b0100000);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                alu_op  = alu_fn(func3, func7[5]);
                illegal = !(f7_zero || (f7_alt &&
                          (func3 == 3'b000 || func3 == 3'b101)));
            end
            OP_I: begin
                // only SRAI may carry func7[5]
                alu_op = alu_fn(func3, (func3 == 3'b101) && func7[5]);
                if (func3 == 3'b001)
                    illegal = !f7_zero;
                else if (func3 == 3'b101)
                    illegal = !(f7_zero || f7_alt);
            end
            OP_LOAD:
                illegal = (func3 == 3'b011) || (func3[2:1] == 2'b11);
            OP_STORE:
                illegal = func3[2] || (func3[1:0] == 2'b11);
            OP_BR:
                illegal = (func3[2:1] == 2'b01);
            OP_JALR:
                illegal = (func3 != 3'b000);
            OP_JAL, OP_LUI, OP_AUIPC: ;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM for a shared-memory datapath.
// Moore outputs; write enables are held off while reset is low.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE   = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 32
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   mem,
    input  logic [6:0]          opcode,
    input  logic [2:0]          func3,
    input  logic [6:0]          func7,
    input  logic                Zero,
    input  logic                Lt,
    input  logic                Ltu,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic                AdrSrc,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ImmSrc,
    output logic [3:0]          ALUControl,
    output logic                illegal,
    output logic [CNT_W-1:0]    instret,
    output logic [3:0]          state_dbg
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       rdy, taken, retire;
    logic       irw, pcw, rgw, mw;
    logic [3:0] dec_op;
    logic       dec_ill;

    alu_decoder u_dec (
        .opcode  (opcode),
        .func3   (func3),
        .func7   (func7),
        .alu_op  (dec_op),
        .illegal (dec_ill)
    );

    assign rdy = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;

    always_comb begin
        case (func3)
            3'b000:  taken = Zero;
            3'b001:  taken = ~Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = ~Lt;
            3'b110:  taken = Ltu;
            3'b111:  taken = ~Ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem.mem_req = 1'b0;
        irw         = 1'b0;
        pcw         = 1'b0;
        rgw         = 1'b0;
        mw          = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_B;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                ALUSrcB     = SRCB_4;
                ResultSrc   = RES_ALU;
                irw         = rdy;
                pcw         = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (dec_ill) state_d = S_TRAP;
                else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:     state_d = S_EXECR;
                        OP_I:     state_d = S_EXECI;
                        OP_BR:    state_d = S_BRANCH;
                        OP_JAL:   state_d = S_JAL;
                        OP_JALR:  state_d = S_JALR;
                        OP_LUI:   state_d = S_LUI;
                        OP_AUIPC: state_d = S_AUIPC;
                        default:  state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem.mem_req = 1'b1;
                AdrSrc      = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                mem.mem_req = 1'b1;
                AdrSrc      = 1'b1;
                mw          = rdy;
                if (rdy) state_d = S_FETCH;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rgw       = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_A;
                ALUControl = dec_op;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_op;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                rgw     = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                pcw        = taken;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALR_LINK: begin
                // PC takes the target in ALUOut while ALU forms OldPC+4
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_4;
                pcw     = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                state_d = S_JALR_LINK;
            end
            S_LUI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_PASSB;
                state_d    = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                if (!HALT_ON_ILLEGAL) state_d = S_FETCH;
            end
        endcase
    end

    assign retire = (state_d == S_FETCH) &&
                    (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});
    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign IRWrite         = irw & reset;
    assign PCWrite         = pcw & reset;
    assign RegWrite        = rgw & reset;
    assign mem.MemWrite    = mw & reset;
    assign ImmSrc          = imm_src(opcode);
    assign mem.MemSize     = (state_q == S_MEMREAD || state_q == S_MEMWRITE)
                             ? func3[1:0] : 2'b10;
    assign mem.MemUnsigned = (state_q == S_MEMREAD) & func3[2];
    assign illegal         = (state_q == S_TRAP);
    assign instret         = instret_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: halting and skipping trap variants.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_multicycle_ctrl;

    logic       clk, reset, rdy;
    logic [6:0] opcode, func7;
    logic [2:0] func3;
    logic       Zero, Lt, Ltu;

    logic [1:0]       irw, pcw, rgw, adr, ill;
    logic [1:0][1:0]  rsrc, srca, srcb;
    logic [1:0][2:0]  imm;
    logic [1:0][3:0]  aluc, st;
    logic [1:0][31:0] cnt;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl_if m0 ();
    multicycle_ctrl_if m1 ();
    assign m0.mem_ready = rdy;
    assign m1.mem_ready = rdy;

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .mem(m0),
        .opcode(opcode), .func3(func3), .func7(func7),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
        .IRWrite(irw[0]), .PCWrite(pcw[0]), .RegWrite(rgw[0]),
        .AdrSrc(adr[0]), .ResultSrc(rsrc[0]), .ALUSrcA(srca[0]),
        .ALUSrcB(srcb[0]), .ImmSrc(imm[0]), .ALUControl(aluc[0]),
        .illegal(ill[0]), .instret(cnt[0]), .state_dbg(st[0])
    );

    multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .HALT_ON_ILLEGAL(1'b0), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .mem(m1),
        .opcode(opcode), .func3(func3), .func7(func7),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
        .IRWrite(irw[1]), .PCWrite(pcw[1]), .RegWrite(rgw[1]),
        .AdrSrc(adr[1]), .ResultSrc(rsrc[1]), .ALUSrcA(srca[1]),
        .ALUSrcB(srcb[1]), .ImmSrc(imm[1]), .ALUControl(aluc[1]),
        .illegal(ill[1]), .instret(cnt[1]), .state_dbg(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp_st);
        @(negedge clk);
        #1;
        chk(tag, 32'(st[0]), 32'(exp_st));
    endtask

    initial begin
        reset = 1'b0; rdy = 1'b1;
        opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;

        @(negedge clk); #1;
        chk("rst_state", 32'(st[0]), 0);
        chk("rst_instret", cnt[0], 0);
        chk("rst_memreq", 32'(m0.mem_req), 1);
        chk("rst_irwrite", 32'(irw[0]), 0);
        chk("rst_pcwrite", 32'(pcw[0]), 0);
        chk("rst_illegal", 32'(ill[0]), 0);

        // load, then reset while waiting in MEMREAD
        reset = 1'b1; opcode = 7'b0000011; func3 = 3'b010;
        #1;
        chk("fetch_irwrite", 32'(irw[0]), 1);
        step("abort_dec", 4'd1);
        step("abort_adr", 4'd2);
        rdy = 1'b0;
        step("abort_rd", 4'd3);
        step("abort_rd_hold", 4'd3);
        reset = 1'b0; #1;
        chk("abort_state", 32'(st[0]), 0);
        chk("abort_instret", cnt[0], 0);
        chk("abort_memreq", 32'(m0.mem_req), 1);
        chk("abort_regwrite", 32'(rgw[0]), 0);
        rdy = 1'b1; #1;
        chk("abort_irw_gated", 32'(irw[0]), 0);
        reset = 1'b1;

        // add
        opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0000000;
        step("add_dec", 4'd1);
        chk("add_dec_srca", 32'(srca[0]), 1);
        step("add_ex", 4'd6);
        chk("add_aluc", 32'(aluc[0]), 0);
        chk("add_srca", 32'(srca[0]), 2);
        step("add_wb", 4'd8);
        chk("add_regwrite", 32'(rgw[0]), 1);
        step("add_fetch", 4'd0);
        chk("add_instret", cnt[0], 1);

        // sub
        func7 = 7'b0100000;
        step("sub_dec", 4'd1);
        step("sub_ex", 4'd6);
        chk("sub_aluc", 32'(aluc[0]), 1);
        step("sub_wb", 4'd8);
        step("sub_fetch", 4'd0);
        chk("sub_instret", cnt[0], 2);

        // bge, Lt=0 -> taken
        opcode = 7'b1100011; func3 = 3'b101; func7 = 7'b0000000; Lt = 1'b0;
        step("bge_dec", 4'd1);
        step("bge_br", 4'd9);
        chk("bge_pcwrite", 32'(pcw[0]), 1);
        chk("bge_aluc", 32'(aluc[0]), 1);
        step("bge_fetch", 4'd0);

        // bltu, Ltu=0 -> not taken
        func3 = 3'b110; Ltu = 1'b0;
        step("bltu_dec", 4'd1);
        step("bltu_br", 4'd9);
        chk("bltu_pcwrite", 32'(pcw[0]), 0);
        Ltu = 1'b1; #1;
        chk("bltu_taken", 32'(pcw[0]), 1);
        Ltu = 1'b0;
        step("bltu_fetch", 4'd0);
        chk("br_instret", cnt[0], 4);

        // lw with 2 fetch waits and 3 read waits: 10 cycles
        opcode = 7'b0000011; func3 = 3'b010; rdy = 1'b0;
        #1;
        chk("lw_f1_irw", 32'(irw[0]), 0);
        chk("lw_f1_req", 32'(m0.mem_req), 1);
        step("lw_f2", 4'd0);
        chk("lw_f2_irw", 32'(irw[0]), 0);
        chk("lw_f2_req", 32'(m0.mem_req), 1);
        step("lw_f3", 4'd0);
        rdy = 1'b1; #1;
        chk("lw_f3_irw", 32'(irw[0]), 1);
        step("lw_dec", 4'd1);
        chk("lw_dec_irw", 32'(irw[0]), 0);
        step("lw_adr", 4'd2);
        rdy = 1'b0;
        step("lw_r1", 4'd3);
        chk("lw_req", 32'(m0.mem_req), 1);
        chk("lw_adrsrc", 32'(adr[0]), 1);
        chk("lw_size", 32'(m0.MemSize), 2);
        chk("lw_unsigned", 32'(m0.MemUnsigned), 0);
        step("lw_r2", 4'd3);
        step("lw_r3", 4'd3);
        step("lw_r4", 4'd3);
        rdy = 1'b1;
        step("lw_wb", 4'd5);
        chk("lw_regwrite", 32'(rgw[0]), 1);
        chk("lw_ressrc", 32'(rsrc[0]), 1);
        chk("lw_size_idle", 32'(m0.MemSize), 2);
        step("lw_fetch", 4'd0);
        chk("lw_instret", cnt[0], 5);

        // sh with one write wait
        opcode = 7'b0100011; func3 = 3'b001;
        step("sh_dec", 4'd1);
        chk("sh_immsrc", 32'(imm[0]), 1);
        step("sh_adr", 4'd2);
        chk("sh_srca", 32'(srca[0]), 2);
        chk("sh_srcb", 32'(srcb[0]), 1);
        rdy = 1'b0;
        step("sh_wr", 4'd4);
        chk("sh_memwrite_wait", 32'(m0.MemWrite), 0);
        chk("sh_size", 32'(m0.MemSize), 1);
        rdy = 1'b1; #1;
        chk("sh_memwrite", 32'(m0.MemWrite), 1);
        step("sh_fetch", 4'd0);
        chk("sh_instret", cnt[0], 6);

        // jalr
        opcode = 7'b1100111; func3 = 3'b000;
        step("jalr_dec", 4'd1);
        step("jalr_tgt", 4'd11);
        chk("jalr_srca", 32'(srca[0]), 2);
        chk("jalr_srcb", 32'(srcb[0]), 1);
        chk("jalr_immsrc", 32'(imm[0]), 0);
        step("jalr_link", 4'd12);
        chk("jalr_pcwrite", 32'(pcw[0]), 1);
        chk("jalr_ressrc", 32'(rsrc[0]), 0);
        chk("jalr_link_srca", 32'(srca[0]), 1);
        chk("jalr_link_srcb", 32'(srcb[0]), 2);
        step("jalr_wb", 4'd8);
        chk("jalr_regwrite", 32'(rgw[0]), 1);
        step("jalr_fetch", 4'd0);
        chk("jalr_instret", cnt[0], 7);

        // lui
        opcode = 7'b0110111;
        step("lui_dec", 4'd1);
        chk("lui_immsrc", 32'(imm[0]), 4);
        step("lui_st", 4'd13);
        chk("lui_aluc", 32'(aluc[0]), 10);
        step("lui_wb", 4'd8);
        step("lui_fetch", 4'd0);
        chk("lui_instret", cnt[0], 8);

        // illegal opcode: dut0 halts, dut1 skips
        opcode = 7'b0000000; func3 = 3'b000;
        step("ill_dec", 4'd1);
        step("ill_trap", 4'd15);
        chk("ill_flag0", 32'(ill[0]), 1);
        chk("ill_flag1", 32'(ill[1]), 1);
        chk("ill_state1", 32'(st[1]), 15);
        chk("ill_req0", 32'(m0.mem_req), 0);
        chk("ill_en0", {28'd0, irw[0], pcw[0], rgw[0], m0.MemWrite}, 0);
        step("ill_hold", 4'd15);
        chk("ill_sticky0", 32'(ill[0]), 1);
        chk("ill_en_hold0", {28'd0, irw[0], pcw[0], rgw[0], m0.MemWrite}, 0);
        chk("ill_skip_state1", 32'(st[1]), 0);
        chk("ill_pulse1", 32'(ill[1]), 0);
        chk("ill_instret0", cnt[0], 8);
        chk("ill_instret1", cnt[1], 8);
        step("ill_hold2", 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle RV32I control unit driving the shared-memory datapath (PC, OldPC, IR, A/B, ALUOut, Data registers). It extends the earlier controller with full RV32I base decode (all branch conditions, JALR, LUI, AUIPC, sized loads/stores), a memory ready handshake, illegal-instruction trapping and a retired-instruction counter. It is a Moore FSM plus a small combinational ALU decoder and sits between the IR fields/ALU flags and every datapath enable and mux select.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
- HALT_ON_ILLEGAL, 1: 1 = illegal instruction parks the FSM in TRAP; 0 = skip the instruction, return to FETCH.
- CNT_W, 32: width of instret.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately.
- opcode  in  7  IR[6:0].
- func3  in  3  IR[14:12].
- func7  in  7  IR[31:25].
- Zero, Lt, Ltu  in  1 each  ALU flags from the current ALU result (a-b: equal, signed less, unsigned less).
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access requested.
- IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc  out  1 each  datapath enables/select.
- ResultSrc, ALUSrcA, ALUSrcB  out  2 each  mux selects.
- ImmSrc  out  3  immediate format.
- ALUControl  out  4  ALU operation.
- MemSize  out  2  func3[1:0] during memory states (00 byte, 01 half, 10 word), else 10.
- MemUnsigned  out  1  func3[2] during MEMREAD, else 0.
- illegal  out  1  illegal instruction flag.
- instret  out  CNT_W  retired-instruction count.
- state_dbg  out  4  current state code.

## Operation
- Encodings: AdrSrc 0=PC, 1=ALUOut. ALUSrcA 00=PC, 01=OldPC, 10=A. ALUSrcB 00=B, 01=Imm, 10=const 4. ResultSrc 00=ALUOut, 01=Data, 10=ALUResult. ImmSrc 000 I, 001 S, 010 B, 011 J, 100 U. ALUControl: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- Outputs are a pure function of state (plus decoded IR fields and flags). Any output not listed for a state is 0. ImmSrc always follows opcode.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch/JAL target into ALUOut). Dispatches on opcode: load/store to MEMADR, 0110011 to EXECR, 0010011 to EXECI, 1100011 to BRANCH, 1101111 to JAL, 1100111 to JALR, 0110111 to LUI, 0010111 to AUIPC. Anything else, or an illegal func3/func7, goes to TRAP.
- MEMADR: A+Imm, ADD. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=mem_ready. Goes to FETCH on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00; the ALU op comes from alu_decoder (func7[5] selects SUB/SRA). Next ALUWB.
- EXECI: ALUSrcB=01. func7[5] is honoured only for shifts (SRAI). Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BRANCH: A vs B, SUB, ResultSrc=00. PCWrite=taken, where taken is: beq Zero, bne ~Zero, blt Lt, bge ~Lt, bltu Ltu, bgeu ~Ltu. func3 010/011 are illegal. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Next ALUWB (rd = OldPC+4).
- JALR: A+Imm into ALUOut; func3≠000 is illegal. Next JALR_LINK.
- JALR_LINK: same outputs as JAL. Next ALUWB.
- LUI: ALUSrcB=01, PASSB. Next ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ADD. Next ALUWB.
- TRAP: illegal set (sticky until reset). With HALT_ON_ILLEGAL=1 it stays in TRAP with all enables 0. With HALT_ON_ILLEGAL=0, illegal pulses for one cycle and the FSM goes to FETCH; the PC was already advanced, so the instruction is skipped.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH. It wraps modulo 2^CNT_W. TRAP never counts.

## Timing
- Reset: state=FETCH, instret=0, illegal=0. Every output takes its FETCH value combinationally, so mem_req=1 during and right after reset; all write enables are forced to 0 while reset=0.
- Latency with zero memory waits: load 5 cycles, store 4, R/I/LUI/AUIPC/JAL 4, branch 3, JALR 5. Each wait cycle adds 1 to FETCH, MEMREAD or MEMWRITE.
- mem_req holds stable while waiting. Write enables fire only in the ready cycle.
- Reset asserted mid-instruction aborts it; nothing retires.

## Structure
- Package ctrl_pkg: state enum (4-bit), ALU op constants, mux select constants, opcode constants.
- Sub-module alu_decoder: combinational (opcode, func3, func7) to ALUControl plus an illegal flag.

## Test plan
- Reset low mid-MEMREAD, then high: state FETCH, instret=0, mem_req=1, RegWrite=0.
- add then sub, mem_ready tied 1: 4 cycles each, ALUControl 0 then 1 in EXECR, instret=2.
- bge with Lt=0: PCWrite=1 in BRANCH. bltu with Ltu=0: PCWrite=0. Both 3 cycles.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD: 10 cycles total, IRWrite a single pulse, MemSize=10.
- opcode 0000000 with HALT_ON_ILLEGAL=1: TRAP held, illegal=1, no enables. With HALT_ON_ILLEGAL=0: one-cycle pulse, back to FETCH, instret unchanged.
- jalr: DECODE, JALR, JALR_LINK (PCWrite=1, ResultSrc=00), ALUWB (RegWrite=1), 5 cycles.
